// File: rtl/shmcp_n_if.sv
// Load/run control and result bus between a program driver and the shmcp_n processor.
// Latency: none, pure wiring; no backpressure, every signal is sampled or driven unconditionally.
interface shmcp_n_if #(
   parameter int DW = 8,
   parameter int PD = 16
);
   localparam int AW = $clog2(PD);
   localparam int IW = 4 + DW;

   logic          state;
   logic          load;
   logic [IW-1:0] instr;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          halted;
   logic          busy;
   logic [AW-1:0] pc_o;

   modport master (
      output state, load, instr,
      input  out_data, out_valid, halted, busy, pc_o
   );

   modport slave (
      input  state, load, instr,
      output out_data, out_valid, halted, busy, pc_o
   );
endinterface

// File: rtl/shmcp_n.sv
// shmcp_n: two-phase fetch/execute accumulator processor with a serially loaded program memory.
// Latency: 2 cycles per instruction, OUT result pulses the cycle after EXEC; no backpressure, outputs are fire-and-forget.
module shmcp_n #(
   parameter int DW = 8,
   parameter int PD = 16
) (
   input  logic     clk,
   input  logic     rst,
   shmcp_n_if.slave bus
);
   localparam int AW = $clog2(PD);
   localparam int IW = 4 + DW;

   typedef enum logic [1:0] {S_LOAD, S_FETCH, S_EXEC, S_HALT} fsm_t;

   fsm_t          fsm_q;
   logic [IW-1:0] imem_q [PD];
   logic [IW-1:0] ir_q;
   logic [AW-1:0] pc_q, pc_d, load_ptr_q;
   logic [DW-1:0] a_q, a_d, b_q, b_d, out_data_q;
   logic          z_q, z_d, c_q, c_d;
   logic          out_valid_q, halted_q, busy_q;
   logic          out_fire_d;
   logic [3:0]    op;
   logic [DW-1:0] imm;

   assign op  = ir_q[IW-1:DW];
   assign imm = ir_q[DW-1:0];

   // Program memory is deliberately outside the reset domain so a reset can replay it.
   always_ff @(posedge clk) begin
      if (fsm_q == S_LOAD && !bus.state && bus.load)
         imem_q[load_ptr_q] <= bus.instr;
   end

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      z_d        = z_q;
      c_d        = c_q;
      pc_d       = pc_q;
      out_fire_d = 1'b0;
      case (op)
         4'h1: a_d = imm;
         4'h2: {c_d, a_d} = {1'b0, a_q} + {1'b0, imm};
         4'h3: {c_d, a_d} = {1'b0, a_q} - {1'b0, imm};
         4'h4: a_d = a_q & imm;
         4'h5: a_d = a_q | imm;
         4'h6: a_d = a_q ^ imm;
         4'h7: b_d = a_q;
         4'h8: {c_d, a_d} = {1'b0, a_q} + {1'b0, b_q};
         4'h9: pc_d = imm[AW-1:0];
         4'hA: if (z_q) pc_d = imm[AW-1:0];
         4'hB: if (c_q) pc_d = imm[AW-1:0];
         4'hC: out_fire_d = 1'b1;
         4'hD: begin
            c_d = a_q[DW-1];
            a_d = {a_q[DW-2:0], 1'b0};
         end
         4'hE: begin
            c_d = a_q[0];
            a_d = {1'b0, a_q[DW-1:1]};
         end
         default: ;
      endcase
      if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'hD, 4'hE})
         z_d = (a_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= S_LOAD;
         pc_q        <= '0;
         load_ptr_q  <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ir_q        <= '0;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (fsm_q)
            S_LOAD: begin
               if (bus.state) begin
                  fsm_q  <= S_FETCH;
                  busy_q <= 1'b1;
                  pc_q   <= '0;
                  a_q    <= '0;
                  b_q    <= '0;
                  z_q    <= 1'b0;
                  c_q    <= 1'b0;
               end else if (bus.load) begin
                  load_ptr_q <= load_ptr_q + AW'(1);
               end
            end
            S_FETCH: begin
               if (!bus.state) begin
                  fsm_q      <= S_LOAD;
                  busy_q     <= 1'b0;
                  load_ptr_q <= '0;
               end else begin
                  ir_q  <= imem_q[pc_q];
                  pc_q  <= pc_q + AW'(1);
                  fsm_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               a_q  <= a_d;
               b_q  <= b_d;
               z_q  <= z_d;
               c_q  <= c_d;
               pc_q <= pc_d;
               if (out_fire_d) begin
                  out_data_q  <= a_q;
                  out_valid_q <= 1'b1;
               end
               // Leaving run mode wins over HLT: the current instruction still retires.
               if (!bus.state) begin
                  fsm_q      <= S_LOAD;
                  busy_q     <= 1'b0;
                  load_ptr_q <= '0;
               end else if (op == 4'hF) begin
                  fsm_q    <= S_HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else begin
                  fsm_q <= S_FETCH;
               end
            end
            S_HALT: begin
               if (!bus.state) begin
                  fsm_q      <= S_LOAD;
                  halted_q   <= 1'b0;
                  load_ptr_q <= '0;
               end
            end
            default: fsm_q <= S_LOAD;
         endcase
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.halted    = halted_q;
   assign bus.busy      = busy_q;
   assign bus.pc_o      = pc_q;
endmodule

// File: tb/tb_shmcp_n.sv
// Scoreboard bench for shmcp_n: an instruction-level ISA model predicts OUT values, their cycles and the halt point.
module tb_shmcp_n;
   localparam int DW   = 8;
   localparam int PD   = 16;
   localparam int IW   = 4 + DW;
   localparam int MASK = (1 << DW) - 1;

   logic clk = 1'b0;
   logic rst;

   shmcp_n_if #(.DW(DW), .PD(PD)) bus ();
   shmcp_n #(.DW(DW), .PD(PD)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int val;
      int at;
   } exp_t;

   exp_t exp_q[$];
   int   prog_q[$];
   int   mem_img[PD];
   int   vectors  = 0;
   int   errors   = 0;
   logic prev_vld = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Instruction-level reference: each instruction costs two cycles from run entry.
   task automatic model_run(input int c0, output int halt_pc, output int halt_at);
      int a = 0, b = 0, z = 0, cf = 0, pc = 0, t = 0;
      int w, op, imm, s;
      exp_t e;
      halt_pc = -1;
      halt_at = -1;
      for (int step = 0; step < 8 * PD; step++) begin
         w   = mem_img[pc];
         op  = (w >> DW) & 15;
         imm = w & MASK;
         pc  = (pc + 1) % PD;
         t++;
         case (op)
            1:  a = imm;
            2:  begin s = a + imm; cf = (s > MASK) ? 1 : 0; a = s & MASK; end
            3:  begin cf = (a < imm) ? 1 : 0; a = (a - imm) & MASK; end
            4:  a = a & imm;
            5:  a = a | imm;
            6:  a = a ^ imm;
            7:  b = a;
            8:  begin s = a + b; cf = (s > MASK) ? 1 : 0; a = s & MASK; end
            9:  pc = imm % PD;
            10: if (z != 0) pc = imm % PD;
            11: if (cf != 0) pc = imm % PD;
            12: begin e.val = a; e.at = c0 + 2 * t; exp_q.push_back(e); end
            13: begin cf = (a >> (DW - 1)) & 1; a = (a << 1) & MASK; end
            14: begin cf = a & 1; a = a >> 1; end
            15: begin halt_pc = pc; halt_at = c0 + 2 * t; return; end
            default: ;
         endcase
         if (op inside {[1:6], 8, 13, 14}) z = (a == 0) ? 1 : 0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
         check("out_expected", (exp_q.size() > 0), 1);
         check("out_valid_gap", prev_vld, 0);
         if (exp_q.size() > 0) begin
            check("out_data", bus.out_data, exp_q[0].val);
            check("out_cycle", cyc, exp_q[0].at);
            void'(exp_q.pop_front());
         end
      end
      prev_vld <= bus.out_valid;
   end

   task automatic enter_load();
      @(negedge clk);
      bus.state = 1'b0;
      bus.load  = 1'b0;
      repeat (2) @(negedge clk);
      check("load_halted", bus.halted, 0);
      check("load_busy", bus.busy, 0);
   endtask

   task automatic load_prog();
      enter_load();
      foreach (prog_q[i]) begin
         bus.instr = IW'(prog_q[i]);
         bus.load  = 1'b1;
         mem_img[i % PD] = prog_q[i];
         @(negedge clk);
      end
      bus.load = 1'b0;
   endtask

   task automatic wait_halt(input string name, input int hpc, input int hat);
      int n = 0;
      while (!bus.halted && n < 8 * PD + 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_halted"}, bus.halted, 1);
      check({name, "_halt_cycle"}, cyc, hat);
      check({name, "_pc"}, bus.pc_o, hpc);
      check({name, "_busy"}, bus.busy, 0);
      check({name, "_outs_drained"}, exp_q.size(), 0);
   endtask

   // Optional noise holds load high with junk during the run; it must be ignored.
   task automatic run_prog(input string name, input bit noise);
      int c0, hpc, hat;
      bus.state = 1'b1;
      if (noise) begin
         bus.load  = 1'b1;
         bus.instr = IW'($urandom);
      end
      @(posedge clk);
      #1 c0 = cyc;
      model_run(c0, hpc, hat);
      wait_halt(name, hpc, hat);
      bus.load = 1'b0;
   endtask

   task automatic rand_prog();
      int op, imm;
      prog_q = {};
      for (int i = 0; i < PD - 1; i++) begin
         op  = $urandom_range(0, 14);
         imm = $urandom_range(0, MASK);
         if (op inside {9, 10, 11}) imm = $urandom_range(i + 1, PD - 1);
         prog_q.push_back((op << DW) | imm);
      end
      prog_q.push_back('hF00);
   endtask

   initial begin
      int c0, hpc, hat;
      bus.state = 1'b0;
      bus.load  = 1'b0;
      bus.instr = '0;
      rst = 1'b1;
      #1;
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_halted", bus.halted, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_pc", bus.pc_o, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      prog_q = '{'h105, 'h203, 'hC00, 'hF00};
      load_prog();
      run_prog("add", 1'b0);

      prog_q = '{'h1FF, 'h201, 'hB04, 'hF00, 'hC00, 'hF00};
      load_prog();
      run_prog("carry_jc", 1'b0);

      prog_q = '{'h103, 'h301, 'hC00, 'hA05, 'h901, 'hF00};
      load_prog();
      run_prog("countdown", 1'b0);

      prog_q = {};
      prog_q.push_back('h111);
      prog_q.push_back('hC00);
      prog_q.push_back('hF00);
      for (int i = 3; i < 16; i++) prog_q.push_back('h000);
      prog_q.push_back('h133);
      load_prog();
      run_prog("wrap17", 1'b0);

      // Asynchronous abort mid-run, then replay from retained memory.
      prog_q = '{'h103, 'h301, 'hC00, 'hA05, 'h901, 'hF00};
      load_prog();
      bus.state = 1'b1;
      @(posedge clk);
      #1 c0 = cyc;
      model_run(c0, hpc, hat);
      repeat (5) @(negedge clk);
      check("abort_busy_before", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      check("abort_out_data", bus.out_data, 0);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_halted", bus.halted, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_pc", bus.pc_o, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      run_prog("replay", 1'b0);

      prog_q = '{'h1AA, 'hD00, 'hC00, 'hF00};
      load_prog();
      run_prog("shl", 1'b0);
      prog_q = '{'h1AA, 'hD00, 'hB04, 'hF00, 'hC00, 'hF00};
      load_prog();
      run_prog("shl_carry", 1'b0);

      for (int k = 0; k < 8; k++) begin
         rand_prog();
         load_prog();
         run_prog("rand", k[0]);
         if (k[0]) begin
            enter_load();
            run_prog("rand_rerun", 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
